// File: rtl/control_sequencer_pkg.sv
// Shared type definitions for the accumulator CPU: instruction opcodes
// (also used by the ALU) and the eight sequencer phases.
package typedefs;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

endpackage

// File: rtl/control_sequencer.sv
// Eight-phase fetch/execute sequencer for the 8-bit accumulator CPU.
// A free-running phase counter walks the instruction cycle; the strobes
// for PC, IR, accumulator and memory are decoded combinationally from
// the current phase and opcode, so they follow opcode changes within
// the same cycle.
module control_sequencer
    import typedefs::*;
(
    input  logic    clk,
    input  logic    rst,
    input  opcode_t opcode,
    input  logic    zero,
    output logic    mem_rd,
    output logic    load_ir,
    output logic    halt,
    output logic    inc_pc,
    output logic    load_ac,
    output logic    load_pc,
    output logic    mem_wr,
    output state_t  phase
);

    state_t phase_next;
    logic   aluop;
    logic   hltop;
    logic   skzop;
    logic   jmpop;
    logic   stoop;
    logic   skz_taken;

    // Phase register; reset wins over advancement and parks on INST_ADDR.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= INST_ADDR;
        end else begin
            phase <= phase_next;
        end
    end

    // Next phase: a fixed ring with no branches, wrapping after STORE.
    always_comb begin
        phase_next = INST_ADDR;
        case (phase)
            INST_ADDR:  phase_next = INST_FETCH;
            INST_FETCH: phase_next = INST_LOAD;
            INST_LOAD:  phase_next = IDLE;
            IDLE:       phase_next = OP_ADDR;
            OP_ADDR:    phase_next = OP_FETCH;
            OP_FETCH:   phase_next = ALU_OP;
            ALU_OP:     phase_next = STORE;
            STORE:      phase_next = INST_ADDR;
            default:    phase_next = INST_ADDR;
        endcase
    end

    // Opcode decode; an unknown opcode falls to the default and leaves
    // every opcode-dependent term low.
    always_comb begin
        aluop     = 1'b0;
        hltop     = 1'b0;
        skzop     = 1'b0;
        jmpop     = 1'b0;
        stoop     = 1'b0;
        skz_taken = 1'b0;
        case (opcode)
            HLT:     hltop = 1'b1;
            SKZ:     skzop = 1'b1;
            ADD:     aluop = 1'b1;
            AND:     aluop = 1'b1;
            XOR:     aluop = 1'b1;
            LDA:     aluop = 1'b1;
            STO:     stoop = 1'b1;
            JMP:     jmpop = 1'b1;
            default: aluop = 1'b0;
        endcase
        if (skzop && (zero == 1'b1)) begin
            skz_taken = 1'b1;
        end
    end

    // Per-phase strobe decode; zero is only consulted in ALU_OP, so a
    // changing flag elsewhere in the cycle cannot disturb the outputs.
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        unique case (phase)
            INST_ADDR: begin
            end
            INST_FETCH: begin
                mem_rd = 1'b1;
            end
            INST_LOAD: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = hltop;
            end
            OP_FETCH: begin
                mem_rd = aluop;
            end
            ALU_OP: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = skz_taken;
                load_pc = jmpop;
            end
            STORE: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = jmpop;
                load_pc = jmpop;
                mem_wr  = stoop;
            end
        endcase
    end

endmodule
